// File: rtl/poker_deserializer_if.sv
// Signal bundle for poker_deserializer: serial input, LED output handshake and sticky flags.
// lsb_err exists only when POKER_LSB_CHECK_EN is defined.
interface poker_deserializer_if #(
    parameter int unsigned LED_PER_DRIVER = 16,
    parameter int unsigned POKER_MODE     = 9
);
    logic                              data_in;
    logic                              shift_en;
    logic                              frame_start;
    logic                              out_valid;
    logic                              out_ready;
    logic [$clog2(LED_PER_DRIVER)-1:0] out_led;
    logic [3*POKER_MODE-1:0]           out_rgb;
    logic                              overrun;
    logic                              sync_err;
    logic                              err_clr;
`ifdef POKER_LSB_CHECK_EN
    logic                              lsb_err;
`endif

    modport master (
        output data_in, shift_en, frame_start, out_ready, err_clr,
        input  out_valid, out_led, out_rgb, overrun, sync_err
`ifdef POKER_LSB_CHECK_EN
        , input lsb_err
`endif
    );

    modport slave (
        input  data_in, shift_en, frame_start, out_ready, err_clr,
        output out_valid, out_led, out_rgb, overrun, sync_err
`ifdef POKER_LSB_CHECK_EN
        , output lsb_err
`endif
    );
endinterface

// File: rtl/poker_deserializer.sv
// Poker-mode serial receiver: rebuilds an MSB-first bit-plane frame and streams it one LED
// per valid/ready transfer. POKER_LSB_CHECK_EN adds a sticky lsb_err for nonzero low planes.
module poker_deserializer #(
    parameter int unsigned LED_PER_DRIVER = 16,
    parameter int unsigned POKER_MODE     = 9
) (
    input logic                 clk,
    input logic                 nrst,
    poker_deserializer_if.slave bus
);
    localparam int unsigned LedW      = $clog2(LED_PER_DRIVER);
    localparam int unsigned BitW      = $clog2(POKER_MODE);
    localparam int unsigned RgbW      = 3 * POKER_MODE;
    localparam int unsigned FrameW    = LED_PER_DRIVER * RgbW;
    localparam int unsigned IdxW      = $clog2(FrameW);
    localparam int unsigned LsbPlanes = 4;

    localparam logic [LedW-1:0] LedLast = LedW'(LED_PER_DRIVER - 1);
    localparam logic [BitW-1:0] BitTop  = BitW'(POKER_MODE - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [1:0]        ch_q, ch_d;
    logic [LedW-1:0]   led_q, led_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [FrameW-1:0] cap_q, cap_d;
    logic [FrameW-1:0] bank_q, bank_d;
    state_e            state_q, state_d;
    logic [LedW-1:0]   out_led_q, out_led_d;
    logic              overrun_q, overrun_d;
    logic              sync_err_q, sync_err_d;

    logic              at_start;
    logic              load;
    logic              overrun_set;
    logic              sync_set;
    logic              xfer;
    logic              last_xfer;
    logic              bank_free;
    logic [IdxW-1:0]   rgb_base;

    // Flat layout: LED-major, then channel, then bit, so one LED word is a contiguous slice.
    function automatic logic [IdxW-1:0] cap_idx(logic [LedW-1:0] l, logic [1:0] c,
                                                logic [BitW-1:0] b);
        return IdxW'((32'(l) * 3 + 32'(c)) * POKER_MODE + 32'(b));
    endfunction

    assign at_start  = (ch_q == 2'd0) && (led_q == LedLast) && (bit_q == BitTop);
    assign xfer      = (state_q == StStream) && bus.out_ready;
    assign last_xfer = xfer && (out_led_q == LedLast);
    assign bank_free = (state_q == StIdle) || last_xfer;

    always_comb begin
        ch_d        = ch_q;
        led_d       = led_q;
        bit_d       = bit_q;
        cap_d       = cap_q;
        load        = 1'b0;
        overrun_set = 1'b0;
        sync_set    = 1'b0;
        if (bus.frame_start) begin
            sync_set = !at_start;
            ch_d     = 2'd0;
            led_d    = LedLast;
            bit_d    = BitTop;
            if (bus.shift_en) begin
                cap_d[cap_idx(LedLast, 2'd0, BitTop)] = bus.data_in;
                ch_d = 2'd1;
            end
        end else if (bus.shift_en) begin
            cap_d[cap_idx(led_q, ch_q, bit_q)] = bus.data_in;
            if (ch_q != 2'd2) begin
                ch_d = ch_q + 2'd1;
            end else begin
                ch_d = 2'd0;
                if (led_q != '0) begin
                    led_d = led_q - 1'b1;
                end else begin
                    led_d = LedLast;
                    if (bit_q != '0) begin
                        bit_d = bit_q - 1'b1;
                    end else begin
                        bit_d = BitTop;
                        if (bank_free) load = 1'b1;
                        else           overrun_set = 1'b1;
                    end
                end
            end
        end
    end

    // A completing frame may reload the bank on the same edge as the final transfer.
    always_comb begin
        state_d   = state_q;
        out_led_d = out_led_q;
        bank_d    = bank_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d   = StStream;
                    out_led_d = '0;
                    bank_d    = cap_d;
                end
            end
            StStream: begin
                if (load) begin
                    out_led_d = '0;
                    bank_d    = cap_d;
                end else if (last_xfer) begin
                    state_d   = StIdle;
                    out_led_d = '0;
                end else if (xfer) begin
                    out_led_d = out_led_q + 1'b1;
                end
            end
        endcase
    end

    assign overrun_d  = overrun_set | (overrun_q & ~bus.err_clr);
    assign sync_err_d = sync_set | (sync_err_q & ~bus.err_clr);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ch_q       <= 2'd0;
            led_q      <= LedLast;
            bit_q      <= BitTop;
            cap_q      <= '0;
            bank_q     <= '0;
            state_q    <= StIdle;
            out_led_q  <= '0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            led_q      <= led_d;
            bit_q      <= bit_d;
            cap_q      <= cap_d;
            bank_q     <= bank_d;
            state_q    <= state_d;
            out_led_q  <= out_led_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign rgb_base      = IdxW'(32'(out_led_q) * RgbW);
    assign bus.out_valid = (state_q == StStream);
    assign bus.out_led   = out_led_q;
    assign bus.out_rgb   = bank_q[rgb_base +: RgbW];
    assign bus.overrun   = overrun_q;
    assign bus.sync_err  = sync_err_q;

`ifdef POKER_LSB_CHECK_EN
    logic lsb_set;
    logic lsb_err_q, lsb_err_d;

    // The frame_start bit always lands on the top plane, so it can never flag.
    assign lsb_set   = bus.shift_en && bus.data_in && !bus.frame_start &&
                       (32'(bit_q) < LsbPlanes);
    assign lsb_err_d = lsb_set | (lsb_err_q & ~bus.err_clr);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) lsb_err_q <= 1'b0;
        else       lsb_err_q <= lsb_err_d;
    end

    assign bus.lsb_err = lsb_err_q;
`endif
endmodule

// File: tb/tb_poker_deserializer.sv
// Bench for poker_deserializer: stream-position model of the frame plus a queue of pending
// LED words, compared against the DUT every negedge, with literal spot checks.
module tb_poker_deserializer;
    localparam int unsigned NLed = 16;
    localparam int unsigned NBit = 9;

    logic clk = 1'b0;
    logic nrst;

    poker_deserializer_if #(.LED_PER_DRIVER(NLed), .POKER_MODE(NBit)) bus ();

    poker_deserializer #(.LED_PER_DRIVER(NLed), .POKER_MODE(NBit)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  led;
        logic [26:0] rgb;
    } word_t;

    word_t      exp_q [$];
    logic [8:0] mcap [NLed][3];
    logic [8:0] tx [NLed][3];
    int         pos;
    logic       m_ov, m_sync, m_lsb;
    logic       m_xfer, m_done, s_ov, s_sync, s_lsb;
    int         mc, ml, mb;

    int total = 0;
    int bad = 0;
    int words_seen = 0;
    int rdy_mode = 0;
    bit rnd_clr = 1'b0;
    bit run_chk = 1'b0;
    int w0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: stream position n maps to ch=n%3, led=15-(n/3)%16, plane=8-n/48.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            pos    = 0;
            m_ov   = 1'b0;
            m_sync = 1'b0;
            m_lsb  = 1'b0;
        end else begin
            m_xfer = (exp_q.size() != 0) && bus.out_ready;
            m_done = 1'b0;
            s_ov   = 1'b0;
            s_sync = 1'b0;
            s_lsb  = 1'b0;
            if (bus.frame_start) begin
                s_sync = (pos != 0);
                pos    = 0;
            end
            if (bus.shift_en) begin
                mc = pos % 3;
                ml = 15 - (pos / 3) % 16;
                mb = 8 - pos / 48;
                mcap[ml][mc][mb] = bus.data_in;
                s_lsb = bus.data_in && (mb < 4);
                pos++;
                if (pos == 432) begin
                    pos    = 0;
                    m_done = 1'b1;
                end
            end
            if (m_xfer) void'(exp_q.pop_front());
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    for (int l = 0; l < 16; l++)
                        exp_q.push_back({4'(l), mcap[l][2], mcap[l][1], mcap[l][0]});
                end else begin
                    s_ov = 1'b1;
                end
            end
            m_ov   = s_ov | (m_ov & ~bus.err_clr);
            m_sync = s_sync | (m_sync & ~bus.err_clr);
            m_lsb  = s_lsb | (m_lsb & ~bus.err_clr);
        end
    end

    always @(negedge clk) begin
        if (nrst && run_chk) begin
            check("valid", bus.out_valid, exp_q.size() != 0);
            check("overrun", bus.overrun, m_ov);
            check("sync_err", bus.sync_err, m_sync);
`ifdef POKER_LSB_CHECK_EN
            check("lsb_err", bus.lsb_err, m_lsb);
`endif
            if (exp_q.size() != 0) begin
                check("out_led", bus.out_led, exp_q[0].led);
                check("out_rgb", bus.out_rgb, exp_q[0].rgb);
            end
            if (bus.out_valid && bus.out_ready) words_seen++;
        end
    end

    task automatic tick();
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($time / 10) % 3 == 0;
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            3:       bus.out_ready = 1'b0;
            default: ;
        endcase
        if (rnd_clr) bus.err_clr = ($urandom_range(0, 19) == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int n0, input int n1, input int gap, input bit fs);
        for (int n = n0; n < n1; n++) begin
            int c, l, b, k;
            c = n % 3;
            l = 15 - (n / 3) % 16;
            b = 8 - n / 48;
            bus.shift_en    = 1'b1;
            bus.data_in     = tx[l][c][b];
            bus.frame_start = fs && (n == n0);
            tick();
            bus.frame_start = 1'b0;
            bus.shift_en    = 1'b0;
            k = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (k) begin
                bus.data_in = 1'($urandom_range(0, 1));
                tick();
            end
        end
    endtask

    task automatic set_pattern(input int mode);
        for (int l = 0; l < 16; l++) begin
            case (mode)
                0: begin
                    tx[l][2] = 9'(l);
                    tx[l][1] = 9'h1AA;
                    tx[l][0] = 9'h155;
                end
                1: begin
                    for (int c = 0; c < 3; c++) tx[l][c] = 9'($urandom_range(0, 511));
                end
                default: begin
                    tx[l][2] = 9'(l << 4);
                    tx[l][1] = 9'h1A0;
                    tx[l][0] = 9'h150;
                end
            endcase
        end
    endtask

    task automatic drain(input int mode);
        rdy_mode     = mode;
        bus.shift_en = 1'b0;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
        tick();
        check("drain_idle", bus.out_valid, 1'b0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #2;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_led", bus.out_led, 4'd0);
        check("rst_rgb", bus.out_rgb, 27'd0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_sync", bus.sync_err, 1'b0);
`ifdef POKER_LSB_CHECK_EN
        check("rst_lsb", bus.lsb_err, 1'b0);
`endif
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst            = 1'b1;
        bus.data_in     = 1'b0;
        bus.shift_en    = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready   = 1'b0;
        bus.err_clr     = 1'b0;
        #3;
        do_reset();
        run_chk = 1'b1;

        // Basic frame, ready always high; out_valid rises on the edge of bit 432.
        rdy_mode = 0;
        set_pattern(0);
        w0 = words_seen;
        send_bits(0, 431, 0, 1'b0);
        check("lat_before", bus.out_valid, 1'b0);
        send_bits(431, 432, 0, 1'b0);
        check("lat_rise", bus.out_valid, 1'b1);
        check("first_led", bus.out_led, 4'd0);
        check("first_rgb", bus.out_rgb, {9'd0, 9'h1AA, 9'h155});
        check("first_overrun", bus.overrun, 1'b0);
        drain(0);
        check("words_f1", words_seen - w0, 16);

        // shift_en gaps and slow ready.
        rdy_mode = 1;
        w0 = words_seen;
        send_bits(0, 432, 1, 1'b0);
        drain(1);
        check("words_f2", words_seen - w0, 16);

        // Second frame completes with 5 words outstanding.
        rdy_mode = 3;
        w0 = words_seen;
        send_bits(0, 432, 0, 1'b0);
        rdy_mode = 4;
        bus.out_ready = 1'b1;
        repeat (11) tick();
        bus.out_ready = 1'b0;
        check("ovr_led", bus.out_led, 4'd11);
        set_pattern(1);
        rdy_mode = 3;
        send_bits(0, 432, 0, 1'b0);
        check("ovr_set", bus.overrun, 1'b1);
        check("ovr_led_kept", bus.out_led, 4'd11);
        check("ovr_rgb_kept", bus.out_rgb, {9'd11, 9'h1AA, 9'h155});
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("ovr_clr", bus.overrun, 1'b0);
        drain(0);
        check("words_ovr", words_seen - w0, 16);

        // frame_start mid-frame, then at the start position.
        rdy_mode = 0;
        w0 = words_seen;
        set_pattern(1);
        send_bits(0, 100, 0, 1'b0);
        set_pattern(0);
        send_bits(0, 432, 0, 1'b1);
        check("sync_set", bus.sync_err, 1'b1);
        drain(0);
        check("words_sync", words_seen - w0, 16);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        send_bits(0, 432, 0, 1'b1);
        check("sync_clean", bus.sync_err, 1'b0);
        drain(0);

        // Last transfer coincides with the next frame's last bit.
        set_pattern(0);
        rdy_mode = 3;
        send_bits(0, 432, 0, 1'b0);
        set_pattern(1);
        send_bits(0, 431, 0, 1'b0);
        rdy_mode = 4;
        bus.out_ready = 1'b1;
        repeat (15) tick();
        check("coin_led15", bus.out_led, 4'd15);
        bus.shift_en = 1'b1;
        bus.data_in  = tx[0][2][0];
        tick();
        bus.shift_en  = 1'b0;
        bus.out_ready = 1'b0;
        check("coin_valid", bus.out_valid, 1'b1);
        check("coin_led0", bus.out_led, 4'd0);
        check("coin_overrun", bus.overrun, 1'b0);
        check("coin_rgb", bus.out_rgb, {tx[0][2], tx[0][1], tx[0][0]});
        drain(0);

        // A 1 on plane 2 of LED 7 channel 1, all other low planes zero.
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        set_pattern(2);
        tx[7][1][2] = 1'b1;
        rdy_mode = 3;
        send_bits(0, 432, 0, 1'b0);
`ifdef POKER_LSB_CHECK_EN
        check("lsb_set", bus.lsb_err, 1'b1);
`endif
        rdy_mode = 4;
        bus.out_ready = 1'b1;
        repeat (7) tick();
        bus.out_ready = 1'b0;
        check("lsb_led7", bus.out_led, 4'd7);
        check("lsb_rgb7", bus.out_rgb, {9'h070, 9'h1A4, 9'h150});
        drain(0);

        // Randomized frames, gaps, ready, err_clr and one mid-frame resync.
        rdy_mode = 2;
        rnd_clr  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            set_pattern(1);
            if (f == 2) begin
                send_bits(0, int'($urandom_range(1, 431)), 2, 1'b0);
                send_bits(0, 432, 2, 1'b1);
            end else begin
                send_bits(0, 432, 2, 1'b0);
            end
        end
        rnd_clr     = 1'b0;
        bus.err_clr = 1'b0;
        drain(2);

        // Reset mid-stream and mid-frame, then a clean frame.
        set_pattern(1);
        rdy_mode = 3;
        send_bits(0, 432, 0, 1'b0);
        send_bits(0, 200, 0, 1'b0);
        do_reset();
        set_pattern(0);
        rdy_mode = 0;
        w0 = words_seen;
        send_bits(0, 432, 0, 1'b0);
        drain(0);
        check("words_post_rst", words_seen - w0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poker_deserializer.md
# poker_deserializer

- Receive end of the poker-mode serial stream that the framebuffer sends to the LED driver controller.
- Samples one bit per enabled cycle and rebuilds the 16 LED × 3 channel × 9-bit grayscale frame from bit-planes sent MSB-first.
- Hands the completed frame downstream one LED per valid/ready transfer.
- Used as the driver-side shift model in simulation and as an on-FPGA loopback checker.

## Interface
Parameters:
- LED_PER_DRIVER, 16, LEDs per driver chain; sets out_led width ($clog2).
- POKER_MODE, 9, bits per channel; sets channel width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- nrst  in  1  asynchronous active-low reset.
- data_in  in  1  serial bit; sampled only when shift_en=1.
- shift_en  in  1  bit strobe; high exactly on cycles carrying a valid bit.
- frame_start  in  1  sync pulse; restarts capture at the first bit of a frame.
- out_valid  out  1  an LED word is presented.
- out_ready  in  1  downstream accepts the word.
- out_led  out  4  LED index of the presented word.
- out_rgb  out  27  channel 0 in [8:0], channel 1 in [17:9], channel 2 in [26:18].
- overrun  out  1  sticky: a frame completed while the output bank was busy.
- sync_err  out  1  sticky: frame_start arrived mid-frame.
- err_clr  in  1  clears both sticky flags.

## Operation
- Arrival order: channel 0,1,2 per LED; LED 15 down to 0 per plane; plane bit 8 down to 0. This gives 432 bits per frame.
- Capture counters ch, led and bit. Start position is ch=0, led=15, bit=8.
- On each shift_en cycle:
  - data_in is written to capture[led][ch][bit].
  - ch increments; at 2 it wraps to 0 and led decrements.
  - led wraps from 0 to 15 and bit decrements.
  - bit wraps from 0 to 8, which completes the frame.
- Frame completion happens on the shift_en cycle with ch=2, led=0, bit=0.
  - Output bank free: the bank loads the full frame on that edge, including the bit sampled on that edge.
  - Output bank busy: the frame is discarded and overrun is set.
  - In both cases capture returns to the start position.
- Output FSM:
  - States: IDLE and STREAM.
  - IDLE→STREAM on a bank load. out_led=0, out_valid=1.
  - In STREAM, each transfer (out_valid & out_ready) increments out_led.
  - A transfer at out_led=15 returns the FSM to IDLE, drops out_valid and frees the bank.
- out_rgb is a combinational mux of the bank by out_led.
- frame_start:
  - Forces capture to the start position.
  - If the counters were not at the start position, the partial frame is dropped and sync_err is set.
  - If shift_en is high in the same cycle, that bit is stored as ch0/led15/bit8 of the new frame, and the counter advances to ch=1.
- err_clr clears both flags. If a set condition occurs in the same cycle, set wins.

## Timing
- Reset values:
  - out_valid=0, out_led=0, out_rgb=0, overrun=0, sync_err=0.
  - Capture at the start position, FSM in IDLE, bank and capture array zeroed.
- Reset asserted mid-frame or mid-stream abandons all data immediately (asynchronous).
- Latency: out_valid rises on the same edge that samples the last frame bit.
- A transfer at out_led=15 and a frame completion on the same edge count as bank free. The new frame loads, out_valid stays 1, out_led=0, no overrun.
- out_valid never drops while in STREAM without a transfer.
- shift_en gaps of any length are tolerated. Counters hold while shift_en=0.
- out_ready is ignored in IDLE.

## Configuration
- POKER_LSB_CHECK_EN defined: adds output lsb_err (sticky, cleared by err_clr). It is set when any bit with bit index 3..0 is received as 1, because the framebuffer zero-pads those planes.
- POKER_LSB_CHECK_EN undefined: port absent, and low planes are stored like any other.

## Test plan
- Reset, then 432 shift_en bits encoding LED k = {ch2=k, ch1=0x1AA, ch0=0x155}, out_ready=1 → 16 consecutive words with out_led 0..15 and matching out_rgb. out_valid rises on the edge of bit 432 and overrun=0.
- Same frame with shift_en toggling 1/0 and out_ready high only every third cycle → identical words, no word lost or duplicated.
- Second frame completes while 5 words of the first remain unaccepted → overrun=1, remaining first-frame words unchanged. err_clr → overrun=0.
- frame_start after 100 bits, then a full frame → sync_err=1 and only the second frame is output. frame_start at the start position leaves sync_err=0.
- Last transfer (out_led=15) on the same edge as the next frame's last bit → out_valid stays 1, out_led=0 with the new data, overrun=0.
- With POKER_LSB_CHECK_EN, a 1 sent at bit 2 of LED 7 ch1 → lsb_err=1. Without the macro the stored value has bit 2 set.
